pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter stage for the MIPS pipeline's IF stage. It replaces the free-standing PC+4 adder with a registered PC, a configurable incrementer, redirect muxing, stall handling and a halt state machine.
- It drives the instruction-memory address and hands PC+INC to IF/ID for link and branch-offset arithmetic.

Parameters:
- PC_WIDTH, 32, width of PC and all address ports.
- PC_INC, 4, increment per fetch, in bytes.
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst_n  input  1  synchronous, active-low reset.
- i_stall  input  1  hazard unit: hold PC this cycle.
- i_branch_taken  input  1  ID-stage branch resolved taken.
- i_branch_target  input  PC_WIDTH  branch destination.
- i_jump  input  1  J/JAL/JR redirect.
- i_jump_target  input  PC_WIDTH  jump destination.
- i_halt  input  1  HALT instruction decoded in ID.
- o_pc  output  PC_WIDTH  current fetch address (registered).
- o_pc_inc  output  PC_WIDTH  o_pc + PC_INC, combinational, modulo 2^PC_WIDTH.
- o_fetch_valid  output  1  fetch at o_pc is meaningful this cycle.
- o_halted  output  1  core halted (registered).

Behaviour:
- Reset: one clock and one synchronous, active-low reset; i_rst_n low at a rising edge loads o_pc=RESET_VECTOR, state=RUN, o_halted=0. o_fetch_valid is 0 while i_rst_n is low and 1 from the first cycle after release. Reset mid-operation (including from HALTED or STEP_WAIT) overrides everything.
- States: RUN, HALTED (plus STEP_WAIT with the optional feature).
- Next-PC priority in RUN, highest first:
  1. i_halt
  2. i_jump
  3. i_branch_taken
  4. i_stall
  5. increment
- i_halt in RUN: PC holds and the state moves to HALTED. o_halted=1 and o_fetch_valid=0 from the next cycle onward.
- HALTED: PC frozen and all inputs ignored until reset.
- i_jump: o_pc <= i_jump_target next cycle. A simultaneous i_branch_taken is ignored.
- i_branch_taken (no jump): o_pc <= i_branch_target.
- Redirect beats i_stall. A control transfer must not be lost behind a load-use stall.
- i_stall alone: o_pc holds; o_fetch_valid stays 1 (same address refetched).
- Increment: o_pc <= o_pc + PC_INC, truncated to PC_WIDTH. Wrap-around at 2^PC_WIDTH is silent (e.g. 0xFFFFFFFC -> 0x00000000).
- Latency: every redirect or increment is visible on o_pc exactly one cycle after the sampling edge. o_pc_inc tracks o_pc combinationally with zero latency.
- Targets are used as given. Alignment is not checked.

Optional Feature:
- Macro: PC_UNIT_STEP_EN. Adds input i_step_mode (1 bit) and input i_step (1-bit pulse from the debug unit), plus state STEP_WAIT.
- With the macro defined:
  - While i_step_mode=1, the unit moves from RUN to STEP_WAIT after each PC update; o_fetch_valid=0 in STEP_WAIT.
  - An i_step pulse returns it to RUN for exactly one cycle, during which one normal next-PC update is performed.
  - i_stall or a redirect in that cycle behaves as in RUN.
  - i_halt during the step cycle goes to HALTED.
  - Clearing i_step_mode in STEP_WAIT returns to RUN without a PC change.
- Without the macro: the ports and state are absent, and behaviour is identical to the macro defined with i_step_mode=0.

Decomposition:
- Shared package/header: state encodings (ST_RUN=2'b00, ST_HALTED=2'b01, ST_STEP_WAIT=2'b10) and the default PC_INC / RESET_VECTOR constants, reused by the debug unit.
- One natural sub-module: pc_adder (parametrised PC_WIDTH-wide i_adder + PC_INC -> o_adder, combinational), instantiated once for o_pc_inc.

Test Plan:
- Reset then 3 free-running cycles, RESET_VECTOR=0 -> o_pc = 0x0, 0x4, 0x8, 0xC; o_pc_inc = o_pc+4; o_fetch_valid=1.
- i_stall=1 for 2 cycles at o_pc=0x8 -> o_pc holds at 0x8 for both, then 0xC.
- i_stall=1, i_branch_taken=1, target 0x40 in the same cycle -> next o_pc=0x40. Adding i_jump=1, target 0x100 in the same cycle -> 0x100.
- Force o_pc=0xFFFFFFFC via jump, then free-run -> o_pc=0x00000000 next cycle, no error flag.
- i_halt at o_pc=0x20 -> o_pc stays 0x20, o_halted=1, o_fetch_valid=0. Later jumps are ignored. i_rst_n low for 1 cycle -> o_pc=0x0, o_halted=0.
- (PC_UNIT_STEP_EN) i_step_mode=1 -> o_pc advances exactly one PC_INC per i_step pulse and holds otherwise.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared state encodings and default constants for the IF-stage
// program counter; also consumed by the debug unit.
package pc_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_HALTED    = 2'b01,
    ST_STEP_WAIT = 2'b10
  } pc_state_e;

  localparam int unsigned DEF_PC_WIDTH     = 32;
  localparam int unsigned DEF_PC_INC       = 4;
  localparam int unsigned DEF_RESET_VECTOR = 0;

  // Redirect request as seen by the next-PC mux.
  typedef struct packed {
    logic jump;
    logic branch;
    logic stall;
  } pc_ctrl_t;

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control/redirect inputs and fetch outputs of the PC stage.
// With PC_UNIT_STEP_EN defined the debug single-step signals are added.
interface pc_unit_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic                i_stall;
  logic                i_branch_taken;
  logic [PC_WIDTH-1:0] i_branch_target;
  logic                i_jump;
  logic [PC_WIDTH-1:0] i_jump_target;
  logic                i_halt;
`ifdef PC_UNIT_STEP_EN
  logic                i_step_mode;
  logic                i_step;
`endif
  logic [PC_WIDTH-1:0] o_pc;
  logic [PC_WIDTH-1:0] o_pc_inc;
  logic                o_fetch_valid;
  logic                o_halted;

  // Pipeline / hazard / debug side.
  modport master (
    output i_stall, i_branch_taken, i_branch_target, i_jump, i_jump_target, i_halt,
`ifdef PC_UNIT_STEP_EN
    output i_step_mode, i_step,
`endif
    input  o_pc, o_pc_inc, o_fetch_valid, o_halted
  );

  // PC unit side.
  modport slave (
    input  i_stall, i_branch_taken, i_branch_target, i_jump, i_jump_target, i_halt,
`ifdef PC_UNIT_STEP_EN
    input  i_step_mode, i_step,
`endif
    output o_pc, o_pc_inc, o_fetch_valid, o_halted
  );
endinterface

// File: rtl/pc_unit_adder.sv
// pc_adder: combinational PC incrementer, wraps silently modulo 2^PC_WIDTH.
module pc_adder #(
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned PC_INC   = 4
) (
  input  logic [PC_WIDTH-1:0] i_adder,
  output logic [PC_WIDTH-1:0] o_adder
);
  assign o_adder = i_adder + PC_WIDTH'(PC_INC);
endmodule

// File: rtl/pc_unit.sv
// pc_unit: registered program counter for the IF stage with redirect muxing,
// stall hold and a halt state machine. Optional debug single-step is
// enabled by defining PC_UNIT_STEP_EN.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned         PC_WIDTH     = DEF_PC_WIDTH,
  parameter int unsigned         PC_INC       = DEF_PC_INC,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(DEF_RESET_VECTOR)
) (
  input logic        i_clk,
  input logic        i_rst_n,
  pc_unit_if.slave   bus
);

  pc_state_e           state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] next_pc;
  pc_ctrl_t            ctrl;

  pc_adder #(
    .PC_WIDTH (PC_WIDTH),
    .PC_INC   (PC_INC)
  ) u_adder (
    .i_adder (pc),
    .o_adder (pc_inc)
  );

  assign ctrl = '{jump: bus.i_jump, branch: bus.i_branch_taken, stall: bus.i_stall};

  // Next-PC mux: jump beats branch, any redirect beats stall, else increment.
  always_comb begin
    next_pc = pc_inc;
    if (ctrl.jump)        next_pc = bus.i_jump_target;
    else if (ctrl.branch) next_pc = bus.i_branch_target;
    else if (ctrl.stall)  next_pc = pc;
  end

  // PC register and run/halt(/step) state machine; halt outranks all redirects.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc    <= RESET_VECTOR;
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.i_halt) begin
            state <= ST_HALTED;
          end else begin
            pc <= next_pc;
`ifdef PC_UNIT_STEP_EN
            // A stalled step still consumes the step; the refetch needs another pulse.
            if (bus.i_step_mode) state <= ST_STEP_WAIT;
`endif
          end
        end
        ST_HALTED: state <= ST_HALTED;
`ifdef PC_UNIT_STEP_EN
        ST_STEP_WAIT: begin
          if (!bus.i_step_mode || bus.i_step) state <= ST_RUN;
        end
`endif
        default: state <= ST_RUN;
      endcase
    end
  end

  // Fetch is only meaningful while running and out of reset.
  assign bus.o_pc          = pc;
  assign bus.o_pc_inc      = pc_inc;
  assign bus.o_halted      = (state == ST_HALTED);
  assign bus.o_fetch_valid = i_rst_n && (state == ST_RUN);

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit (RESET_VECTOR=0, PC_INC=4).
// Step-mode scenario is compiled only with PC_UNIT_STEP_EN defined.
module tb_pc_unit;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  pc_unit_if #(.PC_WIDTH(32)) bus ();

  pc_unit #(
    .PC_WIDTH     (32),
    .PC_INC       (4),
    .RESET_VECTOR (32'h0)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_stall         = 1'b0;
    bus.i_branch_taken  = 1'b0;
    bus.i_branch_target = 32'h0;
    bus.i_jump          = 1'b0;
    bus.i_jump_target   = 32'h0;
    bus.i_halt          = 1'b0;
`ifdef PC_UNIT_STEP_EN
    bus.i_step_mode     = 1'b0;
    bus.i_step          = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    tests++; if (bus.o_pc !== 32'h0) begin fails++; $display("FAIL reset_pc got %h want %h", bus.o_pc, 32'h0); end
    tests++; if (bus.o_halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %b want 0", bus.o_halted); end
    tests++; if (bus.o_fetch_valid !== 1'b0) begin fails++; $display("FAIL reset_valid_low got %b want 0", bus.o_fetch_valid); end
    rst_n = 1'b1;
    #1;
    tests++; if (bus.o_fetch_valid !== 1'b1) begin fails++; $display("FAIL reset_valid_rel got %b want 1", bus.o_fetch_valid); end
    tests++; if (bus.o_pc_inc !== 32'h4) begin fails++; $display("FAIL reset_pc_inc got %h want %h", bus.o_pc_inc, 32'h4); end
  endtask

  task automatic test_increment();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (bus.o_pc !== exp_pc[i]) begin fails++; $display("FAIL inc_pc[%0d] got %h want %h", i, bus.o_pc, exp_pc[i]); end
      tests++; if (bus.o_pc_inc !== exp_pc[i] + 32'h4) begin fails++; $display("FAIL inc_pc_inc[%0d] got %h want %h", i, bus.o_pc_inc, exp_pc[i] + 32'h4); end
      tests++; if (bus.o_fetch_valid !== 1'b1) begin fails++; $display("FAIL inc_valid[%0d] got %b want 1", i, bus.o_fetch_valid); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick();
    bus.i_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++; if (bus.o_pc !== 32'h8) begin fails++; $display("FAIL stall_hold[%0d] got %h want %h", i, bus.o_pc, 32'h8); end
      tests++; if (bus.o_fetch_valid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d] got %b want 1", i, bus.o_fetch_valid); end
    end
    bus.i_stall = 1'b0;
    tick();
    tests++; if (bus.o_pc !== 32'hC) begin fails++; $display("FAIL stall_release got %h want %h", bus.o_pc, 32'hC); end
  endtask

  task automatic test_redirect();
    do_reset();
    bus.i_stall = 1'b1; bus.i_branch_taken = 1'b1; bus.i_branch_target = 32'h40;
    tick();
    tests++; if (bus.o_pc !== 32'h40) begin fails++; $display("FAIL branch_over_stall got %h want %h", bus.o_pc, 32'h40); end
    bus.i_jump = 1'b1; bus.i_jump_target = 32'h100;
    tick();
    tests++; if (bus.o_pc !== 32'h100) begin fails++; $display("FAIL jump_over_branch got %h want %h", bus.o_pc, 32'h100); end
    idle_inputs();
    bus.i_branch_taken = 1'b1; bus.i_branch_target = 32'h200;
    tick();
    tests++; if (bus.o_pc !== 32'h200) begin fails++; $display("FAIL branch_only got %h want %h", bus.o_pc, 32'h200); end
    idle_inputs();
    bus.i_jump = 1'b1; bus.i_jump_target = 32'h123;
    tick();
    tests++; if (bus.o_pc !== 32'h123) begin fails++; $display("FAIL jump_unaligned got %h want %h", bus.o_pc, 32'h123); end
    idle_inputs();
    tick();
    tests++; if (bus.o_pc !== 32'h127) begin fails++; $display("FAIL inc_unaligned got %h want %h", bus.o_pc, 32'h127); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.i_jump = 1'b1; bus.i_jump_target = 32'hFFFF_FFFC;
    tick();
    idle_inputs();
    tests++; if (bus.o_pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_top got %h want %h", bus.o_pc, 32'hFFFF_FFFC); end
    tests++; if (bus.o_pc_inc !== 32'h0) begin fails++; $display("FAIL wrap_pc_inc got %h want %h", bus.o_pc_inc, 32'h0); end
    tick();
    tests++; if (bus.o_pc !== 32'h0) begin fails++; $display("FAIL wrap_pc got %h want %h", bus.o_pc, 32'h0); end
    tests++; if (bus.o_halted !== 1'b0 || bus.o_fetch_valid !== 1'b1) begin fails++; $display("FAIL wrap_flags got h=%b v=%b want h=0 v=1", bus.o_halted, bus.o_fetch_valid); end
  endtask

  task automatic test_halt();
    do_reset();
    bus.i_jump = 1'b1; bus.i_jump_target = 32'h20;
    tick();
    idle_inputs();
    bus.i_halt = 1'b1; bus.i_jump = 1'b1; bus.i_jump_target = 32'h500;
    tick();
    bus.i_halt = 1'b0;
    tests++; if (bus.o_pc !== 32'h20) begin fails++; $display("FAIL halt_pc got %h want %h", bus.o_pc, 32'h20); end
    tests++; if (bus.o_halted !== 1'b1) begin fails++; $display("FAIL halt_flag got %b want 1", bus.o_halted); end
    tests++; if (bus.o_fetch_valid !== 1'b0) begin fails++; $display("FAIL halt_valid got %b want 0", bus.o_fetch_valid); end
    bus.i_jump_target = 32'h300;
    tick(); tick();
    tests++; if (bus.o_pc !== 32'h20 || bus.o_halted !== 1'b1) begin fails++; $display("FAIL halt_ignore got pc=%h h=%b want pc=20 h=1", bus.o_pc, bus.o_halted); end
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tests++; if (bus.o_pc !== 32'h0 || bus.o_halted !== 1'b0) begin fails++; $display("FAIL halt_reset got pc=%h h=%b want pc=0 h=0", bus.o_pc, bus.o_halted); end
    rst_n = 1'b1;
    tick();
    tests++; if (bus.o_pc !== 32'h4 || bus.o_fetch_valid !== 1'b1) begin fails++; $display("FAIL halt_resume got pc=%h v=%b want pc=4 v=1", bus.o_pc, bus.o_fetch_valid); end
  endtask

`ifdef PC_UNIT_STEP_EN
  task automatic test_step();
    do_reset();
    bus.i_step_mode = 1'b1;
    tick();
    tests++; if (bus.o_pc !== 32'h4 || bus.o_fetch_valid !== 1'b0) begin fails++; $display("FAIL step_enter got pc=%h v=%b want pc=4 v=0", bus.o_pc, bus.o_fetch_valid); end
    tick(); tick();
    tests++; if (bus.o_pc !== 32'h4) begin fails++; $display("FAIL step_hold got %h want %h", bus.o_pc, 32'h4); end
    for (int i = 0; i < 2; i++) begin
      bus.i_step = 1'b1;
      tick();
      bus.i_step = 1'b0;
      tests++; if (bus.o_fetch_valid !== 1'b1) begin fails++; $display("FAIL step_run_valid[%0d] got %b want 1", i, bus.o_fetch_valid); end
      tick();
      tests++; if (bus.o_pc !== 32'h8 + 32'(i) * 32'h4) begin fails++; $display("FAIL step_adv[%0d] got %h want %h", i, bus.o_pc, 32'h8 + 32'(i) * 32'h4); end
      tick();
      tests++; if (bus.o_pc !== 32'h8 + 32'(i) * 32'h4) begin fails++; $display("FAIL step_wait[%0d] got %h want %h", i, bus.o_pc, 32'h8 + 32'(i) * 32'h4); end
    end
    bus.i_step_mode = 1'b0;
    tick();
    tests++; if (bus.o_pc !== 32'hC || bus.o_fetch_valid !== 1'b1) begin fails++; $display("FAIL step_exit got pc=%h v=%b want pc=C v=1", bus.o_pc, bus.o_fetch_valid); end
    tick();
    tests++; if (bus.o_pc !== 32'h10) begin fails++; $display("FAIL step_free got %h want %h", bus.o_pc, 32'h10); end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_increment();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
`ifdef PC_UNIT_STEP_EN
    test_step();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
